// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin two-master bus arbiter with single-cycle slave enables and read timeout
module bus_arbiter #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32,
    parameter int unsigned TIMEOUT = 15,
    parameter logic [DW-1:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_rd_en,
    input  logic          m0_wr_en,
    input  logic [DW-1:0] m0_wr_data,
    input  logic [3:0]    m0_wr_mask,
    output logic [DW-1:0] m0_rd_data,
    output logic          m0_rd_valid,
    output logic          m0_wr_done,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_rd_en,
    input  logic          m1_wr_en,
    input  logic [DW-1:0] m1_wr_data,
    input  logic [3:0]    m1_wr_mask,
    output logic [DW-1:0] m1_rd_data,
    output logic          m1_rd_valid,
    output logic          m1_wr_done,
    output logic [AW-1:0] s_addr,
    output logic          s_rd_en,
    output logic          s_wr_en,
    output logic [DW-1:0] s_wr_data,
    output logic [3:0]    s_wr_mask,
    input  logic [DW-1:0] s_rd_data,
    input  logic          s_rd_valid,
    output logic [1:0]    grant,
    output logic          timeout_err,
    output logic [7:0]    timeout_cnt
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
    logic [1:0] state;
    logic       last_grant;
    logic       is_wr;
    logic [7:0] cnt;
    logic       req0, req1, pick1, expire;
    // Lone requester wins; a tie goes to the master not served last. Expiry loses to a same-cycle valid.
    always_comb begin
        req0   = m0_rd_en | m0_wr_en;
        req1   = m1_rd_en | m1_wr_en;
        pick1  = req1 & (~req0 | ~last_grant);
        expire = (state == WAIT) & ~s_rd_valid & (cnt == 8'(TIMEOUT - 1));
    end
    assign s_rd_en     = (state == ISSUE) & ~is_wr;
    assign s_wr_en     = (state == ISSUE) & is_wr;
    assign m0_rd_valid = (state == RESP) & grant[0] & ~is_wr;
    assign m0_wr_done  = (state == RESP) & grant[0] & is_wr;
    assign m1_rd_valid = (state == RESP) & grant[1] & ~is_wr;
    assign m1_wr_done  = (state == RESP) & grant[1] & is_wr;
    assign timeout_err = expire;
    // Sequencer: latch the winner, issue one enable, wait for data or timeout, then respond
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant       <= '0;
            is_wr       <= 1'b0;
            cnt         <= '0;
            timeout_cnt <= '0;
            s_addr      <= '0;
            s_wr_data   <= '0;
            s_wr_mask   <= '0;
            m0_rd_data  <= '0;
            m1_rd_data  <= '0;
        end else begin
            case (state)
                IDLE: if (req0 | req1) begin
                    s_addr     <= pick1 ? m1_addr : m0_addr;
                    s_wr_data  <= pick1 ? m1_wr_data : m0_wr_data;
                    s_wr_mask  <= pick1 ? m1_wr_mask : m0_wr_mask;
                    is_wr      <= pick1 ? m1_wr_en : m0_wr_en;
                    grant      <= pick1 ? 2'b10 : 2'b01;
                    last_grant <= pick1;
                    state      <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= is_wr ? RESP : WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (s_rd_valid | expire) begin
                        if (grant[1]) m1_rd_data <= s_rd_valid ? s_rd_data : TIMEOUT_DATA;
                        else m0_rd_data <= s_rd_valid ? s_rd_data : TIMEOUT_DATA;
                        state <= RESP;
                    end
                    if (expire && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
                end
                RESP: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table plus hand sequences, completions checked through a scoreboard queue
module tb_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] m0_addr, m1_addr, s_addr;
    logic        m0_rd_en, m0_wr_en, m1_rd_en, m1_wr_en;
    logic [31:0] m0_wr_data, m1_wr_data, m0_rd_data, m1_rd_data, s_wr_data, s_rd_data;
    logic [3:0]  m0_wr_mask, m1_wr_mask, s_wr_mask;
    logic        m0_rd_valid, m0_wr_done, m1_rd_valid, m1_wr_done;
    logic        s_rd_en, s_wr_en, s_rd_valid, timeout_err;
    logic [1:0]  grant;
    logic [7:0]  timeout_cnt;

    typedef struct {
        int m; int wr; int both;
        logic [15:0] addr; logic [31:0] wdata; logic [3:0] mask;
        int lat; logic [31:0] rdata;
        logic [31:0] exp_data; int exp_cyc; int exp_to;
    } vec_t;
    typedef struct { int m; int wr; logic [31:0] data; } exp_t;

    exp_t sbq[$];
    exp_t sb_e;
    logic [3:0] pulses;
    vec_t vecs[9];
    int errors = 0;
    int checks = 0;
    int exp_tcnt = 0;

    bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m0_addr), .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en),
        .m0_wr_data(m0_wr_data), .m0_wr_mask(m0_wr_mask),
        .m0_rd_data(m0_rd_data), .m0_rd_valid(m0_rd_valid), .m0_wr_done(m0_wr_done),
        .m1_addr(m1_addr), .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en),
        .m1_wr_data(m1_wr_data), .m1_wr_mask(m1_wr_mask),
        .m1_rd_data(m1_rd_data), .m1_rd_valid(m1_rd_valid), .m1_wr_done(m1_wr_done),
        .s_addr(s_addr), .s_rd_en(s_rd_en), .s_wr_en(s_wr_en),
        .s_wr_data(s_wr_data), .s_wr_mask(s_wr_mask),
        .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid),
        .grant(grant), .timeout_err(timeout_err), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_m(input int m, input int rd, input int wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] k);
        if (m == 0) begin
            m0_rd_en = rd != 0; m0_wr_en = wr != 0; m0_addr = a; m0_wr_data = d; m0_wr_mask = k;
        end else begin
            m1_rd_en = rd != 0; m1_wr_en = wr != 0; m1_addr = a; m1_wr_data = d; m1_wr_mask = k;
        end
    endtask

    // Scoreboard: every completion pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n) begin
            pulses = {m1_wr_done, m1_rd_valid, m0_wr_done, m0_rd_valid};
            for (int i = 0; i < 2; i++) begin
                if (pulses[2*i+:2] != 2'b00) begin
                    if (sbq.size() == 0) check("unexpected_pulse", 32'(pulses), 0);
                    else begin
                        sb_e = sbq.pop_front();
                        check("sb_master", i, sb_e.m);
                        check("sb_kind", 32'(pulses[2*i+:2]), sb_e.wr != 0 ? 2 : 1);
                        if (sb_e.wr == 0) check("sb_rdata", i != 0 ? m1_rd_data : m0_rd_data, sb_e.data);
                    end
                end
            end
        end
    end

    // One transaction from one master with a slave answering lat cycles after s_rd_en (0 = never)
    task automatic do_txn(input vec_t v);
        int done_c = 0;
        int to_n = 0;
        int to_c = 0;
        @(posedge clk); #1;
        set_m(v.m, (v.wr == 0 || v.both != 0) ? 1 : 0, v.wr, v.addr, v.wdata, v.mask);
        sbq.push_back('{v.m, v.wr, v.exp_data});
        for (int c = 1; c <= 40 && done_c == 0; c++) begin
            @(posedge clk); #1;
            s_rd_valid = v.wr == 0 && v.lat > 0 && c == 1 + v.lat;
            s_rd_data = s_rd_valid ? v.rdata : $urandom;
            @(negedge clk);
            check("grant", 32'(grant), v.m != 0 ? 2 : 1);
            if (c == 1) begin
                check("s_rd_en", 32'(s_rd_en), 32'(v.wr == 0));
                check("s_wr_en", 32'(s_wr_en), 32'(v.wr != 0));
                check("s_addr", 32'(s_addr), 32'(v.addr));
                if (v.wr != 0) begin
                    check("s_wr_data", s_wr_data, v.wdata);
                    check("s_wr_mask", 32'(s_wr_mask), 32'(v.mask));
                end
            end
            if (timeout_err) begin to_n++; to_c = c; end
            if (v.m != 0 ? (m1_rd_valid | m1_wr_done) : (m0_rd_valid | m0_wr_done)) done_c = c;
        end
        check("latency", done_c, v.exp_cyc);
        check("timeout_pulses", to_n, v.exp_to);
        if (v.exp_to != 0) check("timeout_err_cycle", to_c, v.exp_cyc - 1);
        if (v.exp_to != 0 && exp_tcnt < 255) exp_tcnt++;
        @(posedge clk); #1;
        set_m(v.m, 0, 0, 16'h0, 32'h0, 4'h0);
        s_rd_valid = 1'b0;
        check("timeout_cnt", 32'(timeout_cnt), exp_tcnt);
    endtask

    // Both masters write and hold their requests for n grants; grants must alternate
    task automatic contend(input int n, input int first);
        int k = 0;
        int issues = 0;
        int last_issue = 0;
        @(posedge clk); #1;
        set_m(0, 0, 1, 16'h0A00, 32'h0A0A0A0A, 4'h3);
        set_m(1, 0, 1, 16'h0B00, 32'h0B0B0B0B, 4'hC);
        for (int j = 0; j < n; j++) sbq.push_back('{(first + j) % 2, 1, 32'h0});
        for (int c = 1; c <= 10 * n && k < n; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (s_wr_en) begin
                int m;
                m = (first + issues) % 2;
                check("ct_grant", 32'(grant), m != 0 ? 2 : 1);
                check("ct_addr", 32'(s_addr), m != 0 ? 32'h0B00 : 32'h0A00);
                check("ct_data", s_wr_data, m != 0 ? 32'h0B0B0B0B : 32'h0A0A0A0A);
                check("ct_mask", 32'(s_wr_mask), m != 0 ? 32'hC : 32'h3);
                check("ct_spacing", c - last_issue, issues == 0 ? 1 : 3);
                last_issue = c;
                issues++;
            end
            if (m0_wr_done | m1_wr_done) k++;
        end
        check("ct_done", k, n);
        @(posedge clk); #1;
        set_m(0, 0, 0, 16'h0, 32'h0, 4'h0);
        set_m(1, 0, 0, 16'h0, 32'h0, 4'h0);
    endtask

    initial begin
        vecs = '{
            '{0, 0, 0, 16'h0010, 32'h0, 4'h0, 1,  32'h12345678, 32'h12345678, 3,  0},
            '{1, 1, 0, 16'h0200, 32'hCAFEF00D, 4'hF, 0, 32'h0, 32'h0, 2, 0},
            '{1, 0, 0, 16'hF000, 32'h0, 4'h0, 0,  32'h0,         32'hDEADBEEF, 17, 1},
            '{0, 0, 0, 16'h0020, 32'h0, 4'h0, 15, 32'hA5A50001, 32'hA5A50001, 17, 0},
            '{1, 0, 0, 16'h0030, 32'h0, 4'h0, 3,  32'h0BADCAFE, 32'h0BADCAFE, 5,  0},
            '{0, 1, 1, 16'h0044, 32'h11223344, 4'h5, 0, 32'h0, 32'h0, 2, 0},
            '{0, 1, 0, 16'h0048, 32'h55667788, 4'h8, 0, 32'h0, 32'h0, 2, 0},
            '{1, 0, 0, 16'h0050, 32'h0, 4'h0, 16, 32'h99999999, 32'hDEADBEEF, 17, 1},
            '{0, 0, 0, 16'h0060, 32'h0, 4'h0, 14, 32'h13579BDF, 32'h13579BDF, 16, 0}
        };
        rst_n = 1'b0;
        set_m(0, 0, 0, 16'h0, 32'h0, 4'h0);
        set_m(1, 0, 0, 16'h0, 32'h0, 4'h0);
        s_rd_valid = 1'b0;
        s_rd_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(grant), 0);
        check("rst_s_rd_en", 32'(s_rd_en), 0);
        check("rst_s_wr_en", 32'(s_wr_en), 0);
        check("rst_s_addr", 32'(s_addr), 0);
        check("rst_s_wr_data", s_wr_data, 0);
        check("rst_s_wr_mask", 32'(s_wr_mask), 0);
        check("rst_m0_rd_data", m0_rd_data, 0);
        check("rst_m1_rd_data", m1_rd_data, 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_timeout_cnt", 32'(timeout_cnt), 0);
        check("rst_pulses", 32'({m1_wr_done, m1_rd_valid, m0_wr_done, m0_rd_valid}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        contend(3, 0);
        contend(2, 1);
        for (int i = 0; i < 9; i++) do_txn(vecs[i]);
        // Reset while an m0 read sits in WAIT; the late slave response must be dropped
        @(posedge clk); #1;
        set_m(0, 1, 0, 16'h0123, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rw_wait_grant", 32'(grant), 1);
        rst_n = 1'b0;
        set_m(0, 0, 0, 16'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_rd_valid = 1'b1;
        s_rd_data = 32'h77777777;
        exp_tcnt = 0;
        @(negedge clk);
        check("rw_grant", 32'(grant), 0);
        check("rw_timeout_cnt", 32'(timeout_cnt), 0);
        check("rw_m0_rd_data", m0_rd_data, 0);
        @(posedge clk); #1;
        s_rd_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rw_idle_grant", 32'(grant), 0);
            check("rw_idle_s_en", 32'({s_rd_en, s_wr_en}), 0);
            check("rw_idle_m0_rd_data", m0_rd_data, 0);
        end
        do_txn('{1, 0, 0, 16'h0070, 32'h0, 4'h0, 2, 32'h2468ACE0, 32'h2468ACE0, 4, 0});
        // Timeout counter must saturate after 256 timeouts
        for (int i = 0; i < 256; i++)
            do_txn('{i % 2, 0, 0, 16'(16'hE000 + i), 32'h0, 4'h0, 0, 32'h0, 32'hDEADBEEF, 17, 1});
        check("sat_timeout_cnt", 32'(timeout_cnt), 255);
        check("sb_leftover", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
